// File: rtl/traffic_pkg.sv
// traffic_pkg: definitions shared by the light phase timer and the light FSM.
//   phase_t        : phase encoding RED=00, GREEN=01, YELLOW=10 (11 is unused)
//   DEF_*_TICKS    : default phase durations in tick_en pulses
//   DEF_MIN_GREEN  : default minimum green before a pedestrian cut
//   dur_eff()      : maps a configured duration to the one actually used
package traffic_pkg;

  typedef enum logic [1:0] {
    RED    = 2'b00,
    GREEN  = 2'b01,
    YELLOW = 2'b10
  } phase_t;

  localparam int DEF_RED_TICKS    = 50;
  localparam int DEF_GREEN_TICKS  = 40;
  localparam int DEF_YELLOW_TICKS = 10;
  localparam int DEF_MIN_GREEN    = 10;

  // A zero (or negative) duration would leave nothing to count; run it as one tick.
  function automatic int dur_eff(input int ticks);
    return (ticks < 1) ? 1 : ticks;
  endfunction

endpackage

// File: rtl/phase_counter.sv
// phase_counter: loadable down-counter that stops at zero.
//   clk      : rising-edge clock
//   load     : load count from load_val (wins over dec)
//   load_val : value to load
//   dec      : decrement by one; ignored when count is already zero
//   count    : current count
//   zero     : count == 0
// The count carries no reset of its own; the owner reloads it through load.
module phase_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             zero
);

  always_ff @(posedge clk) begin
    if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/light_phase_timer.sv
// light_phase_timer: times the RED -> GREEN -> YELLOW -> RED phases of a
// traffic light and emits a one-cycle advance pulse at each phase change.
//   clk       : rising-edge clock
//   reset     : synchronous active-high reset (back to RED, full red duration)
//   tick_en   : time-base strobe; the phase count moves only when high
//   ped_req   : pedestrian button (level or single-cycle pulse)
//   advance   : one-cycle pulse, registered, the cycle after a phase change
//   phase     : current phase (RED=00, GREEN=01, YELLOW=10)
//   remaining : ticks left in the current phase, minus one
//   ped_ack   : one-cycle pulse alongside the advance into RED that serves a request
// Build option: define PED_REQ_EN to enable pedestrian requests (remembered
// until the next RED entry, may cut GREEN short after MIN_GREEN ticks). With
// it undefined, ped_req is ignored and ped_ack is held at 0.
module light_phase_timer
  import traffic_pkg::*;
#(
  parameter int CNT_W        = 16,
  parameter int RED_TICKS    = DEF_RED_TICKS,
  parameter int GREEN_TICKS  = DEF_GREEN_TICKS,
  parameter int YELLOW_TICKS = DEF_YELLOW_TICKS,
  parameter int MIN_GREEN    = DEF_MIN_GREEN
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick_en,
  input  logic             ped_req,
  output logic             advance,
  output logic [1:0]       phase,
  output logic [CNT_W-1:0] remaining,
  output logic             ped_ack
);

  localparam int RED_D    = dur_eff(RED_TICKS);
  localparam int GREEN_D  = dur_eff(GREEN_TICKS);
  localparam int YELLOW_D = dur_eff(YELLOW_TICKS);

  localparam logic [CNT_W-1:0] RED_LOAD    = CNT_W'(RED_D - 1);
  localparam logic [CNT_W-1:0] GREEN_LOAD  = CNT_W'(GREEN_D - 1);
  localparam logic [CNT_W-1:0] YELLOW_LOAD = CNT_W'(YELLOW_D - 1);

  phase_t           phase_q;
  phase_t           phase_nxt;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] load_val;
  logic             cnt_zero;
  logic             cnt_load;
  logic             cnt_dec;
  logic             phase_bad;
  logic             phase_end;
  logic             early_cut;

  phase_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk      (clk),
    .load     (cnt_load),
    .load_val (load_val),
    .dec      (cnt_dec),
    .count    (count),
    .zero     (cnt_zero)
  );

  always_comb begin
    phase_nxt = RED;
    load_val  = RED_LOAD;
    phase_bad = 1'b0;
    case (phase_q)
      RED: begin
        phase_nxt = GREEN;
        load_val  = GREEN_LOAD;
      end
      GREEN: begin
        phase_nxt = YELLOW;
        load_val  = YELLOW_LOAD;
      end
      YELLOW: begin
        phase_nxt = RED;
        load_val  = RED_LOAD;
      end
      default: phase_bad = 1'b1;
    endcase
    // Reset and the stray 11 encoding both restart a full RED.
    if (reset || phase_bad) begin
      load_val = RED_LOAD;
    end
    phase_end = tick_en && (cnt_zero || early_cut) && !phase_bad;
    cnt_load  = reset || phase_end || phase_bad;
    cnt_dec   = tick_en && !cnt_load;
  end

`ifdef PED_REQ_EN
  localparam int MIN_G    = (MIN_GREEN < 0) ? 0 : MIN_GREEN;
  localparam bit EARLY_OK = (MIN_G < GREEN_D);
  // Ticks consumed after this tick are GREEN_D - count, so the cut is allowed
  // once count <= GREEN_D - MIN_G.
  localparam logic [CNT_W-1:0] CUT_THR = CNT_W'(EARLY_OK ? (GREEN_D - MIN_G) : 0);

  logic ped_pending;

  assign early_cut = EARLY_OK && (phase_q == GREEN) && ped_pending && (count <= CUT_THR);
`else
  localparam int unused_min_green = MIN_GREEN;
  logic unused_ped_req;

  assign unused_ped_req = ped_req;
  assign early_cut      = 1'b0;
  assign ped_ack        = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q <= RED;
      advance <= 1'b0;
`ifdef PED_REQ_EN
      ped_pending <= 1'b0;
      ped_ack     <= 1'b0;
`endif
    end else begin
      if (phase_end || phase_bad) begin
        phase_q <= phase_nxt;
      end
      advance <= phase_end;
`ifdef PED_REQ_EN
      // A request is served (and forgotten) at the change into RED.
      ped_ack <= phase_end && (phase_nxt == RED) && ped_pending;
      if (phase_end && (phase_nxt == RED)) begin
        ped_pending <= 1'b0;
      end else if (ped_req) begin
        ped_pending <= 1'b1;
      end
`endif
    end
  end

  assign phase     = phase_q;
  assign remaining = count;

endmodule

// File: tb/tb_light_phase_timer.sv
// tb_light_phase_timer: directed bench for light_phase_timer.
//   dut_a : RED=3, GREEN=4, YELLOW=2, MIN_GREEN=2
//   dut_b : RED=3, GREEN=8, YELLOW=0 (runs as 1), MIN_GREEN=2
// Cycle 0 of a scenario is the first cycle after the reset edge; outputs are
// sampled 1 time unit after each rising edge, inputs driven right after.
module tb_light_phase_timer;

  logic        clk = 1'b0;
  logic        reset_a, tick_a, ped_a, adv_a, ack_a;
  logic        reset_b, tick_b, ped_b, adv_b, ack_b;
  logic [1:0]  ph_a, ph_b;
  logic [15:0] rem_a, rem_b;

  int nvec = 0;
  int nmis = 0;

  always #5 clk = ~clk;

  light_phase_timer #(
    .CNT_W(16), .RED_TICKS(3), .GREEN_TICKS(4), .YELLOW_TICKS(2), .MIN_GREEN(2)
  ) dut_a (
    .clk(clk), .reset(reset_a), .tick_en(tick_a), .ped_req(ped_a),
    .advance(adv_a), .phase(ph_a), .remaining(rem_a), .ped_ack(ack_a)
  );

  light_phase_timer #(
    .CNT_W(16), .RED_TICKS(3), .GREEN_TICKS(8), .YELLOW_TICKS(0), .MIN_GREEN(2)
  ) dut_b (
    .clk(clk), .reset(reset_b), .tick_en(tick_b), .ped_req(ped_b),
    .advance(adv_b), .phase(ph_b), .remaining(rem_b), .ped_ack(ack_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_a_now();
    reset_a = 1'b1; tick_a = 1'b0; ped_a = 1'b0;
    step();
    reset_a = 1'b0;
  endtask

  task automatic reset_b_now();
    reset_b = 1'b1; tick_b = 1'b0; ped_b = 1'b0;
    step();
    reset_b = 1'b0;
  endtask

  // Reset held with tick_en and ped_req high must still give the reset state.
  task automatic test_reset();
    reset_a = 1'b1; tick_a = 1'b1; ped_a = 1'b1;
    reset_b = 1'b1; tick_b = 1'b1; ped_b = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step();
      nvec++; if (ph_a !== 2'b00) begin nmis++; $display("FAIL reset_phase_a: got %b want 00", ph_a); end
      nvec++; if (rem_a !== 16'd2) begin nmis++; $display("FAIL reset_rem_a: got %0d want 2", rem_a); end
      nvec++; if (adv_a !== 1'b0) begin nmis++; $display("FAIL reset_adv_a: got %b want 0", adv_a); end
      nvec++; if (ack_a !== 1'b0) begin nmis++; $display("FAIL reset_ack_a: got %b want 0", ack_a); end
      nvec++; if (ph_b !== 2'b00) begin nmis++; $display("FAIL reset_phase_b: got %b want 00", ph_b); end
      nvec++; if (rem_b !== 16'd2) begin nmis++; $display("FAIL reset_rem_b: got %0d want 2", rem_b); end
      nvec++; if (adv_b !== 1'b0) begin nmis++; $display("FAIL reset_adv_b: got %b want 0", adv_b); end
      nvec++; if (ack_b !== 1'b0) begin nmis++; $display("FAIL reset_ack_b: got %b want 0", ack_b); end
    end
  endtask

  // tick_en always high: advance at cycles 3, 7, 9, 12.
  task automatic test_continuous();
    logic [1:0]  exp_ph  [14] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1,
                                  2'd2, 2'd2, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1};
    logic [15:0] exp_rem [14] = '{16'd2, 16'd1, 16'd0, 16'd3, 16'd2, 16'd1, 16'd0,
                                  16'd1, 16'd0, 16'd2, 16'd1, 16'd0, 16'd3, 16'd2};
    logic        exp_adv [14] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
                                  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    reset_a_now();
    for (int c = 0; c < 14; c++) begin
      tick_a = 1'b1;
      nvec++; if (ph_a !== exp_ph[c]) begin nmis++; $display("FAIL cont_phase c=%0d: got %b want %b", c, ph_a, exp_ph[c]); end
      nvec++; if (rem_a !== exp_rem[c]) begin nmis++; $display("FAIL cont_rem c=%0d: got %0d want %0d", c, rem_a, exp_rem[c]); end
      nvec++; if (adv_a !== exp_adv[c]) begin nmis++; $display("FAIL cont_adv c=%0d: got %b want %b", c, adv_a, exp_adv[c]); end
      step();
    end
  endtask

  // tick_en on cycles 3, 7, 11, ...: phases stretch 4x, advance at 12, 28, 36, 48.
  task automatic test_sparse_tick();
    logic [15:0] prev_rem;
    logic        prev_tick;
    logic        want_adv;
    logic [1:0]  want_ph;
    reset_a_now();
    prev_rem  = 16'd0;
    prev_tick = 1'b1;
    for (int c = 0; c < 50; c++) begin
      want_adv = (c == 12) || (c == 28) || (c == 36) || (c == 48);
      nvec++; if (adv_a !== want_adv) begin nmis++; $display("FAIL sparse_adv c=%0d: got %b want %b", c, adv_a, want_adv); end
      if (want_adv) begin
        want_ph = (c == 28) ? 2'd2 : ((c == 36) ? 2'd0 : 2'd1);
        nvec++; if (ph_a !== want_ph) begin nmis++; $display("FAIL sparse_phase c=%0d: got %b want %b", c, ph_a, want_ph); end
      end
      if (!prev_tick) begin
        nvec++; if (rem_a !== prev_rem) begin nmis++; $display("FAIL sparse_hold c=%0d: got %0d want %0d", c, rem_a, prev_rem); end
      end
      prev_rem  = rem_a;
      tick_a    = ((c % 4) == 3);
      prev_tick = tick_a;
      step();
    end
  endtask

  // Reset in GREEN with remaining=2 (a request also pending): back to RED at
  // once, no advance, and the forgotten request does not shorten the next GREEN.
  task automatic test_reset_mid_phase();
    logic want_adv;
    reset_a_now();
    for (int c = 0; c < 4; c++) begin
      tick_a = 1'b1;
      ped_a  = (c == 0);
      step();
    end
    nvec++; if (ph_a !== 2'd1) begin nmis++; $display("FAIL mid_pre_phase: got %b want 01", ph_a); end
    nvec++; if (rem_a !== 16'd2) begin nmis++; $display("FAIL mid_pre_rem: got %0d want 2", rem_a); end
    reset_a = 1'b1;
    step();
    reset_a = 1'b0;
    nvec++; if (ph_a !== 2'd0) begin nmis++; $display("FAIL mid_phase: got %b want 00", ph_a); end
    nvec++; if (rem_a !== 16'd2) begin nmis++; $display("FAIL mid_rem: got %0d want 2", rem_a); end
    for (int c = 0; c < 10; c++) begin
      want_adv = (c == 3) || (c == 7) || (c == 9);
      nvec++; if (adv_a !== want_adv) begin nmis++; $display("FAIL mid_adv c=%0d: got %b want %b", c, adv_a, want_adv); end
      nvec++; if (ack_a !== 1'b0) begin nmis++; $display("FAIL mid_ack c=%0d: got %b want 0", c, ack_a); end
      tick_a = 1'b1;
      step();
    end
  endtask

`ifdef PED_REQ_EN
  // Request on the first GREEN cycle: GREEN ends after 2 ticks, YELLOW lasts
  // 1 tick, ped_ack rides with the advance into RED at cycle 6.
  task automatic test_ped_request();
    logic [1:0] exp_ph  [8] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd0, 2'd0};
    logic       exp_adv [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic       exp_ack [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    reset_b_now();
    for (int c = 0; c < 8; c++) begin
      tick_b = 1'b1;
      ped_b  = (c == 3);
      nvec++; if (ph_b !== exp_ph[c]) begin nmis++; $display("FAIL ped_phase c=%0d: got %b want %b", c, ph_b, exp_ph[c]); end
      nvec++; if (adv_b !== exp_adv[c]) begin nmis++; $display("FAIL ped_adv c=%0d: got %b want %b", c, adv_b, exp_adv[c]); end
      nvec++; if (ack_b !== exp_ack[c]) begin nmis++; $display("FAIL ped_ack c=%0d: got %b want %b", c, ack_b, exp_ack[c]); end
      step();
    end
  endtask
`else
  // ped_req held high is ignored: GREEN runs all 8 ticks, YELLOW (duration 0)
  // runs 1 tick, ped_ack never rises.
  task automatic test_ped_request();
    logic [1:0] want_ph;
    logic       want_adv;
    reset_b_now();
    for (int c = 0; c < 14; c++) begin
      tick_b   = 1'b1;
      ped_b    = 1'b1;
      want_ph  = (c < 3) ? 2'd0 : ((c < 11) ? 2'd1 : ((c == 11) ? 2'd2 : 2'd0));
      want_adv = (c == 3) || (c == 11) || (c == 12);
      nvec++; if (ph_b !== want_ph) begin nmis++; $display("FAIL noped_phase c=%0d: got %b want %b", c, ph_b, want_ph); end
      nvec++; if (adv_b !== want_adv) begin nmis++; $display("FAIL noped_adv c=%0d: got %b want %b", c, adv_b, want_adv); end
      nvec++; if (ack_b !== 1'b0) begin nmis++; $display("FAIL noped_ack c=%0d: got %b want 0", c, ack_b); end
      if (c == 11) begin
        nvec++; if (rem_b !== 16'd0) begin nmis++; $display("FAIL noped_yellow_rem: got %0d want 0", rem_b); end
      end
      step();
    end
  endtask
`endif

  initial begin
    reset_a = 1'b1; tick_a = 1'b0; ped_a = 1'b0;
    reset_b = 1'b1; tick_b = 1'b0; ped_b = 1'b0;
    test_reset();
    test_continuous();
    test_sparse_tick();
    test_reset_mid_phase();
    test_ped_request();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
